// File: rtl/act_requant_unit_pkg.sv
// Shared types and arithmetic helpers for the activation/requantisation datapath.
package act_pkg;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    RELU  = 2'd1,
    LEAKY = 2'd2,
    CLIP  = 2'd3
  } act_mode_t;

  // Wide enough that any element width plus the rounding guard bit fits.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    calc_t value;
    logic  sat;
  } sat_res_t;

  // Round-half-up arithmetic right shift.
  function automatic calc_t round_shift(calc_t v, int unsigned sh);
    calc_t bias;
    bias = (sh == 0) ? '0 : (calc_t'(1) <<< (sh - 1));
    return (v + bias) >>> sh;
  endfunction

  // Clamp to a signed width-bit range, or to [0, max_v] when unsigned.
  function automatic sat_res_t saturate(calc_t v, int unsigned width, logic is_signed,
                                        calc_t max_v);
    calc_t    lo;
    calc_t    hi;
    sat_res_t res;
    if (is_signed) begin
      lo = -(calc_t'(1) <<< (width - 1));
      hi = (calc_t'(1) <<< (width - 1)) - 1;
    end else begin
      lo = '0;
      hi = max_v;
    end
    res.sat   = (v < lo) || (v > hi);
    res.value = (v < lo) ? lo : ((v > hi) ? hi : v);
    return res;
  endfunction

endpackage

// File: rtl/act_requant_unit_if.sv
// Packed element stream with line/frame framing; no back-pressure.
interface act_requant_unit_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         sop;
  logic         eop;
  logic         sof;
  logic         eof;

  modport master (output data, valid, sop, eop, sof, eof);
  modport slave  (input  data, valid, sop, eop, sof, eof);
endinterface

// File: rtl/act_requant_unit_lane.sv
// One lane: activation register, then rounded shift and saturation register.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH   = 24,
  parameter int DATA_O_WIDTH = 8,
  parameter int SHIFT_WIDTH  = 5,
  parameter int CLIP_MAX     = 96
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic signed [DATA_WIDTH-1:0]   x_i,
  input  act_mode_t                      mode_i,
  input  logic        [SHIFT_WIDTH-1:0]  leak_shift_i,
  input  act_mode_t                      mode_s1_i,
  input  logic        [SHIFT_WIDTH-1:0]  shift_s1_i,
  output logic        [DATA_O_WIDTH-1:0] data_o,
  output logic                           sat_o
);

  logic signed [DATA_WIDTH-1:0] y_c;
  logic signed [DATA_WIDTH-1:0] y_q;
  calc_t                        r_c;
  calc_t                        max_c;
  logic                         signed_c;
  sat_res_t                     res_c;

  // Stage 1 activation; CLIP only zeroes negatives here, its ceiling comes after the shift.
  always_comb begin
    y_c = x_i;
    case (mode_i)
      RELU, CLIP: if (x_i < 0) y_c = '0;
      LEAKY:      if (x_i < 0) y_c = x_i >>> leak_shift_i;
      default:    ;
    endcase
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) y_q <= '0;
    else          y_q <= y_c;
  end

  // Stage 2 requantisation and range selection by the mode this beat was activated with.
  always_comb begin
    signed_c = (mode_s1_i == PASS) || (mode_s1_i == LEAKY);
    max_c    = (mode_s1_i == CLIP) ? calc_t'(CLIP_MAX) : ((calc_t'(1) <<< DATA_O_WIDTH) - 1);
    r_c      = round_shift(calc_t'(y_q), int'(shift_s1_i));
    res_c    = saturate(r_c, DATA_O_WIDTH, signed_c, max_c);
    sat_o    = res_c.sat;
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_o <= '0;
    else          data_o <= res_c.value[DATA_O_WIDTH-1:0];
  end

endmodule

// File: rtl/act_requant_unit.sv
// Multi-lane activation + requantisation with per-frame saturation count, 2-cycle latency.
module act_requant_unit
  import act_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DATA_WIDTH   = 24,
  parameter int DATA_O_WIDTH = 8,
  parameter int SHIFT_WIDTH  = 5,
  parameter int CLIP_MAX     = 96,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  act_requant_unit_if.slave      in_s,
  act_requant_unit_if.master     out_m,
  input  logic [1:0]             mode_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  input  logic [SHIFT_WIDTH-1:0] leak_shift_i,
  output logic [CNT_WIDTH-1:0]   sat_cnt_o,
  output logic                   sat_cnt_valid_o
);

  localparam int PW = $clog2(CHANNELS + 1);
  localparam int SW = CNT_WIDTH + PW;
  localparam logic [SW-1:0] CNT_MAX = {{PW{1'b0}}, {CNT_WIDTH{1'b1}}};

  act_mode_t              mode_q, mode_c, mode_s1;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_c, shift_s1;
  logic [SHIFT_WIDTH-1:0] leak_q, leak_c;
  logic                   cfg_load;
  // Framing bundle order: {valid, sop, eop, sof, eof}.
  logic [4:0]             fr_s1, fr_s2;
  logic [CHANNELS-1:0]    sat_c;
  logic [CHANNELS*DATA_O_WIDTH-1:0] data_q;
  logic [PW-1:0]          pop_c;
  logic [SW-1:0]          sum_c;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_next;

  // A sof beat uses its own configuration immediately, so the latch is bypassed on that beat.
  always_comb begin
    cfg_load = in_s.valid && in_s.sof;
    mode_c   = cfg_load ? act_mode_t'(mode_i) : mode_q;
    shift_c  = cfg_load ? shift_i : shift_q;
    leak_c   = cfg_load ? leak_shift_i : leak_q;
  end

  // Configuration latch, default RELU with zero shifts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= RELU;
      shift_q <= '0;
      leak_q  <= '0;
    end else if (cfg_load) begin
      mode_q  <= mode_c;
      shift_q <= shift_c;
      leak_q  <= leak_c;
    end
  end

  // Stage 1 copy of configuration and framing, stage 2 framing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_s1  <= RELU;
      shift_s1 <= '0;
      fr_s1    <= '0;
      fr_s2    <= '0;
    end else begin
      mode_s1  <= mode_c;
      shift_s1 <= shift_c;
      fr_s1    <= {in_s.valid, in_s.sop, in_s.eop, in_s.sof, in_s.eof};
      fr_s2    <= fr_s1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    act_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DATA_O_WIDTH(DATA_O_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH),
      .CLIP_MAX    (CLIP_MAX)
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .x_i         (in_s.data[k*DATA_WIDTH +: DATA_WIDTH]),
      .mode_i      (mode_c),
      .leak_shift_i(leak_c),
      .mode_s1_i   (mode_s1),
      .shift_s1_i  (shift_s1),
      .data_o      (data_q[k*DATA_O_WIDTH +: DATA_O_WIDTH]),
      .sat_o       (sat_c[k])
    );
  end

  assign out_m.data  = data_q;
  assign out_m.valid = fr_s2[4];
  assign out_m.sop   = fr_s2[3];
  assign out_m.eop   = fr_s2[2];
  assign out_m.sof   = fr_s2[1];
  assign out_m.eof   = fr_s2[0];

  // Popcount of saturated lanes and sticky frame-count update; sof restarts from zero.
  always_comb begin
    pop_c = '0;
    for (int k = 0; k < CHANNELS; k++) pop_c = pop_c + PW'(sat_c[k]);
    sum_c    = (fr_s1[1] ? '0 : SW'(cnt_q)) + SW'(pop_c);
    cnt_next = (sum_c > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : sum_c[CNT_WIDTH-1:0];
  end

  // Counter runs on the stage-2 edge so the report lines up with the eof output beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      sat_cnt_o       <= '0;
      sat_cnt_valid_o <= 1'b0;
    end else begin
      sat_cnt_valid_o <= fr_s1[4] && fr_s1[0];
      if (fr_s1[4]) cnt_q <= cnt_next;
      if (fr_s1[4] && fr_s1[0]) sat_cnt_o <= cnt_next;
    end
  end

endmodule

// File: tb/tb_act_requant_unit.sv
// Directed scoreboard bench: expected beats queued at drive time, checked at output.
module tb_act_requant_unit;
  import act_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode_i;
  logic [4:0] shift_i;
  logic [4:0] leak_shift_i;
  logic [2:0] sat_cnt_o;
  logic       sat_cnt_valid_o;

  always #5 clk = ~clk;

  act_requant_unit_if #(.W(96)) in_if ();
  act_requant_unit_if #(.W(32)) out_if ();

  act_requant_unit #(
    .CHANNELS    (4),
    .DATA_WIDTH  (24),
    .DATA_O_WIDTH(8),
    .SHIFT_WIDTH (5),
    .CLIP_MAX    (96),
    .CNT_WIDTH   (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_s           (in_if),
    .out_m          (out_if),
    .mode_i         (mode_i),
    .shift_i        (shift_i),
    .leak_shift_i   (leak_shift_i),
    .sat_cnt_o      (sat_cnt_o),
    .sat_cnt_valid_o(sat_cnt_valid_o)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  fr;
  } exp_t;

  exp_t dq[$];
  int   cq[$];
  int   vectors = 0;
  int   miscompares = 0;
  exp_t mon_e;
  int   mon_c;

  function automatic logic [95:0] pk(int a, int b, int c, int d);
    return {d[23:0], c[23:0], b[23:0], a[23:0]};
  endfunction

  task automatic drive(input logic [95:0] d, input logic sop, input logic eop,
                       input logic sof, input logic eof, input logic [1:0] m,
                       input logic [4:0] sh, input logic [4:0] lk,
                       input logic [31:0] ed, input int ecnt);
    @(negedge clk);
    in_if.data   = d;
    in_if.valid  = 1'b1;
    in_if.sop    = sop;
    in_if.eop    = eop;
    in_if.sof    = sof;
    in_if.eof    = eof;
    mode_i       = m;
    shift_i      = sh;
    leak_shift_i = lk;
    dq.push_back('{ed, {sop, eop, sof, eof}});
    if (eof) cq.push_back(ecnt);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_if.valid = 1'b0;
      in_if.sof   = 1'b0;
      in_if.eof   = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    logic [42:0] obs;
    obs = {out_if.data, out_if.valid, out_if.sop, out_if.eop, out_if.sof, out_if.eof,
           sat_cnt_o, sat_cnt_valid_o};
    vectors++;
    assert (obs === 43'd0) else begin
      miscompares++;
      $error("FAIL %s: outputs got %h expected 0", tag, obs);
    end
  endtask

  // Output monitor: compares every output beat and count report against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_if.valid) begin
        vectors++;
        assert (dq.size() > 0) else begin
          miscompares++;
          $error("FAIL unexpected_beat: got data %h with no beat expected", out_if.data);
        end
        if (dq.size() > 0) begin
          mon_e = dq.pop_front();
          vectors += 2;
          assert (out_if.data === mon_e.d) else begin
            miscompares++;
            $error("FAIL data: got %h expected %h", out_if.data, mon_e.d);
          end
          assert ({out_if.sop, out_if.eop, out_if.sof, out_if.eof} === mon_e.fr) else begin
            miscompares++;
            $error("FAIL framing: got %b expected %b",
                   {out_if.sop, out_if.eop, out_if.sof, out_if.eof}, mon_e.fr);
          end
        end
      end
      if (sat_cnt_valid_o || (out_if.valid && out_if.eof)) begin
        vectors++;
        assert (sat_cnt_valid_o === (out_if.valid && out_if.eof)) else begin
          miscompares++;
          $error("FAIL pulse_align: sat_cnt_valid got %b expected %b",
                 sat_cnt_valid_o, out_if.valid && out_if.eof);
        end
      end
      if (sat_cnt_valid_o) begin
        vectors++;
        assert (cq.size() > 0) else begin
          miscompares++;
          $error("FAIL unexpected_report: got count %0d with no report expected", sat_cnt_o);
        end
        if (cq.size() > 0) begin
          mon_c = cq.pop_front();
          vectors++;
          assert (sat_cnt_o === 3'(mon_c)) else begin
            miscompares++;
            $error("FAIL sat_cnt: got %0d expected %0d", sat_cnt_o, mon_c);
          end
        end
      end
    end
  end

  initial begin
    in_if.data = '0; in_if.valid = 1'b0;
    in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.sof = 1'b0; in_if.eof = 1'b0;
    mode_i = 2'd0; shift_i = '0; leak_shift_i = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset_n = 1'b1;

    // RELU shift 2, LEAKY, CLIP as back-to-back single-beat frames.
    drive(pk(-100, 5, 6, 1100), 1, 1, 1, 1, 2'd1, 5'd2, 5'd0, 32'hFF020100, 1);
    drive(pk(-9, -200, 127, 128), 1, 1, 1, 1, 2'd2, 5'd0, 5'd2, 32'h7F7FCEFD, 1);
    drive(pk(191, 193, 200, -4), 1, 1, 1, 1, 2'd3, 5'd1, 5'd0, 32'h00606060, 2);
    idle(3);

    // Mode change on a non-sof beat is ignored until the next sof.
    drive(pk(-5, 10, 300, 0), 1, 0, 1, 0, 2'd1, 5'd0, 5'd0, 32'h00FF0A00, 0);
    drive(pk(-5, 10, 20, -1), 0, 1, 0, 1, 2'd0, 5'd3, 5'd0, 32'h00140A00, 1);
    drive(pk(-5, 10, -200, 200), 1, 1, 1, 1, 2'd0, 5'd0, 5'd0, 32'h7F800AFB, 2);
    idle(3);

    // Counter sticks at 7 over a three-beat frame, then a single-beat frame reports alone.
    drive(pk(1000, -1000, 500, -500), 1, 0, 1, 0, 2'd0, 5'd0, 5'd0, 32'h807F807F, 0);
    drive(pk(1000, -1000, 500, -500), 0, 0, 0, 0, 2'd3, 5'd4, 5'd0, 32'h807F807F, 0);
    drive(pk(1000, -1000, 500, -500), 0, 1, 0, 1, 2'd1, 5'd1, 5'd0, 32'h807F807F, 7);
    drive(pk(1000, 1, 2, 3), 1, 1, 1, 1, 2'd0, 5'd0, 5'd0, 32'h0302017F, 1);
    idle(3);

    // Open a PASS shift-3 frame, then reset while its second beat sits in stage 1.
    drive(pk(1, 2, 3, 4), 1, 0, 1, 0, 2'd0, 5'd3, 5'd0, 32'h01000000, 0);
    idle(3);
    drive(pk(9, 9, 9, 9), 0, 0, 0, 0, 2'd0, 5'd3, 5'd0, 32'h0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("mid_reset");
    dq.delete();
    cq.delete();
    in_if.valid = 1'b0; in_if.sof = 1'b0; in_if.eof = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(4);

    // Defaults after reset: RELU, shift 0, until a sof loads new settings.
    drive(pk(-7, 9, 300, 3), 0, 0, 0, 0, 2'd0, 5'd3, 5'd0, 32'h03FF0900, 0);
    drive(pk(1, 2, 3, 4), 1, 1, 1, 1, 2'd1, 5'd0, 5'd0, 32'h04030201, 0);
    idle(4);

    for (int i = 0; i < 20 && (dq.size() > 0 || cq.size() > 0); i++) @(negedge clk);
    vectors++;
    assert (dq.size() == 0 && cq.size() == 0) else begin
      miscompares++;
      $error("FAIL drain: got %0d beats and %0d reports outstanding, expected 0",
             dq.size(), cq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
